// File: rtl/alu_arbiter_if.sv
// Request/response and shared-ALU signal bundle for alu_arbiter.
// slave is the arbiter's view; master is the requesters' and ALU's view.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [2:0]            req0_oc;
    logic [DATA_WIDTH-1:0] req0_a;
    logic [DATA_WIDTH-1:0] req0_b;
    logic                  rsp0_valid;
    logic                  rsp0_ready;
    logic [DATA_WIDTH-1:0] rsp0_f;
    logic                  rsp0_err;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [2:0]            req1_oc;
    logic [DATA_WIDTH-1:0] req1_a;
    logic [DATA_WIDTH-1:0] req1_b;
    logic                  rsp1_valid;
    logic                  rsp1_ready;
    logic [DATA_WIDTH-1:0] rsp1_f;
    logic                  rsp1_err;

    logic [2:0]            alu_oc;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH-1:0] alu_f;
    logic                  busy;

    modport slave (
        input  req0_valid, req0_oc, req0_a, req0_b, rsp0_ready,
        input  req1_valid, req1_oc, req1_a, req1_b, rsp1_ready,
        input  alu_f,
        output req0_ready, rsp0_valid, rsp0_f, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_f, rsp1_err,
        output alu_oc, alu_a, alu_b, busy
    );

    modport master (
        output req0_valid, req0_oc, req0_a, req0_b, rsp0_ready,
        output req1_valid, req1_oc, req1_a, req1_b, rsp1_ready,
        output alu_f,
        input  req0_ready, rsp0_valid, rsp0_f, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_f, rsp1_err,
        input  alu_oc, alu_a, alu_b, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters; accept-to-rsp_valid is 2 cycles.
// Result is held until the winner's rsp_ready; requests wait with ready low meanwhile.
module alu_arbiter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    localparam logic [2:0] OC_DIV = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic                  src_q, src_d;
    logic [2:0]            op_oc_q, op_oc_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  err_q, err_d;

    logic gnt_vld;
    logic gnt_id;
    logic rsp_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            src_q   <= 1'b0;
            op_oc_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            src_q   <= src_d;
            op_oc_q <= op_oc_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // On a tie the requester not served last wins.
    always_comb begin
        gnt_vld = bus.req0_valid | bus.req1_valid;
        gnt_id  = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            gnt_id = ~last_q;
        end else if (bus.req1_valid) begin
            gnt_id = 1'b1;
        end
    end

    assign rsp_ack = src_q ? bus.rsp1_ready : bus.rsp0_ready;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        src_d   = src_q;
        op_oc_d = op_oc_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld && !rst) begin
                    src_d   = gnt_id;
                    op_oc_d = gnt_id ? bus.req1_oc : bus.req0_oc;
                    op_a_d  = gnt_id ? bus.req1_a  : bus.req0_a;
                    op_b_d  = gnt_id ? bus.req1_b  : bus.req0_b;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (op_oc_q == OC_DIV && op_b_q == '0) begin
                    res_d = '1;
                    err_d = 1'b1;
                end else begin
                    res_d = bus.alu_f;
                    err_d = 1'b0;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ack) begin
                    last_d  = src_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is masked by rst so nothing looks accepted while reset is held.
    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        if (state_q == IDLE && gnt_vld && !rst) begin
            bus.req0_ready = ~gnt_id;
            bus.req1_ready = gnt_id;
        end
        bus.rsp0_valid = (state_q == RESP) && !src_q;
        bus.rsp1_valid = (state_q == RESP) && src_q;
        bus.rsp0_f     = res_q;
        bus.rsp1_f     = res_q;
        bus.rsp0_err   = err_q;
        bus.rsp1_err   = err_q;
        bus.alu_oc     = op_oc_q;
        bus.alu_a      = op_a_q;
        bus.alu_b      = op_b_q;
        bus.busy       = (state_q != IDLE);
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU model on the shared port.
module tb_alu_arbiter;
    localparam int DW = 16;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    alu_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    alu_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: 000 add, 001 sub, 010 mul, 011 unsigned divide.
    always_comb begin
        bus.alu_f = '0;
        case (bus.alu_oc)
            3'b000: bus.alu_f = bus.alu_a + bus.alu_b;
            3'b001: bus.alu_f = bus.alu_a - bus.alu_b;
            3'b010: bus.alu_f = bus.alu_a * bus.alu_b;
            3'b011: bus.alu_f = (bus.alu_b != '0) ? bus.alu_a / bus.alu_b : '0;
            default: bus.alu_f = '0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int r);
        return (r == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    function automatic logic rvld(input int r);
        return (r == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    endfunction

    function automatic logic [DW-1:0] rf(input int r);
        return (r == 0) ? bus.rsp0_f : bus.rsp1_f;
    endfunction

    function automatic logic rerr(input int r);
        return (r == 0) ? bus.rsp0_err : bus.rsp1_err;
    endfunction

    task automatic drive_req(input int r, input logic v, input logic [2:0] oc,
                             input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (r == 0) begin
            bus.req0_valid = v; bus.req0_oc = oc; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_oc = oc; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdy0"}, bus.req0_ready, 0);
        chk({tag, "_rdy1"}, bus.req1_ready, 0);
        chk({tag, "_rv0"},  bus.rsp0_valid, 0);
        chk({tag, "_rv1"},  bus.rsp1_valid, 0);
        chk({tag, "_f0"},   bus.rsp0_f, 0);
        chk({tag, "_f1"},   bus.rsp1_f, 0);
        chk({tag, "_err"},  {bus.rsp0_err, bus.rsp1_err}, 0);
        chk({tag, "_alu"},  {bus.alu_oc, bus.alu_a, bus.alu_b}, 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    // Full single operation on requester r with rsp_ready held high.
    task automatic do_op(input string tag, input int r, input logic [2:0] oc,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] exp_f, input logic exp_err);
        drive_req(r, 1'b1, oc, a, b);
        if (r == 0) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
        #1;
        for (int i = 0; i < 20 && !rdy(r); i++) tick();
        chk({tag, "_rdy"}, rdy(r), 1);
        chk({tag, "_ordy"}, rdy(1 - r), 0);
        tick();
        drive_req(r, 1'b0, oc, a, b);
        chk({tag, "_exec_busy"}, bus.busy, 1);
        chk({tag, "_exec_vld"}, rvld(r), 0);
        tick();
        chk({tag, "_vld"}, rvld(r), 1);
        chk({tag, "_ovld"}, rvld(1 - r), 0);
        chk({tag, "_f"}, rf(r), exp_f);
        chk({tag, "_err"}, rerr(r), exp_err);
        tick();
        chk({tag, "_idle"}, bus.busy, 0);
        chk({tag, "_done_vld"}, rvld(r), 0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1;
        drive_req(0, 1'b1, 3'b000, 16'h1111, 16'h2222);
        drive_req(1, 1'b0, 3'b000, 16'h0000, 16'h0000);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        drive_req(0, 1'b0, 3'b000, 16'h0000, 16'h0000);
        rst = 1'b0;
        tick();

        // Single add on requester 0, timed edge by edge.
        drive_req(0, 1'b1, 3'b000, 16'h1234, 16'h0FF0);
        bus.rsp0_ready = 1'b1;
        #1;
        chk("add_rdy0", bus.req0_ready, 1);
        chk("add_rdy1", bus.req1_ready, 0);
        tick();
        drive_req(0, 1'b0, 3'b000, 16'h0000, 16'h0000);
        chk("add_t1_busy", bus.busy, 1);
        chk("add_t1_alu_a", bus.alu_a, 16'h1234);
        chk("add_t1_alu_b", bus.alu_b, 16'h0FF0);
        chk("add_t1_vld", bus.rsp0_valid, 0);
        tick();
        chk("add_t2_vld", bus.rsp0_valid, 1);
        chk("add_t2_f", bus.rsp0_f, 16'h2224);
        chk("add_t2_err", bus.rsp0_err, 0);
        chk("add_t2_vld1", bus.rsp1_valid, 0);
        tick();
        chk("add_t3_idle", bus.busy, 0);
        chk("add_t3_vld", bus.rsp0_valid, 0);

        do_op("sub_wrap", 0, 3'b001, 16'h0001, 16'h0002, 16'hFFFF, 1'b0);
        do_op("mul_trunc", 0, 3'b010, 16'h0300, 16'h0100, 16'h0000, 1'b0);
        do_op("div_zero", 0, 3'b011, 16'h0050, 16'h0000, 16'hFFFF, 1'b1);
        do_op("div_seven", 1, 3'b011, 16'h0050, 16'h0007, 16'h000B, 1'b0);

        // Tie held for four operations; last served was 1, so order is 0,1,0,1.
        drive_req(0, 1'b1, 3'b000, 16'h0010, 16'h0001);
        drive_req(1, 1'b1, 3'b001, 16'h0010, 16'h0001);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            int g;
            g = i % 2;
            chk($sformatf("tie%0d_rdy", i), rdy(g), 1);
            chk($sformatf("tie%0d_ordy", i), rdy(1 - g), 0);
            tick();
            chk($sformatf("tie%0d_exec_rdy", i), {bus.req0_ready, bus.req1_ready}, 0);
            tick();
            chk($sformatf("tie%0d_vld", i), rvld(g), 1);
            chk($sformatf("tie%0d_ovld", i), rvld(1 - g), 0);
            chk($sformatf("tie%0d_f", i), rf(g), (g == 0) ? 16'h0011 : 16'h000F);
            chk($sformatf("tie%0d_resp_rdy", i), {bus.req0_ready, bus.req1_ready}, 0);
            tick();
        end
        drive_req(0, 1'b0, 3'b000, 16'h0000, 16'h0000);
        drive_req(1, 1'b0, 3'b000, 16'h0000, 16'h0000);
        #1;

        // Back-pressure on requester 1 while requester 0 waits.
        bus.rsp1_ready = 1'b0;
        bus.rsp0_ready = 1'b1;
        drive_req(1, 1'b1, 3'b010, 16'h0003, 16'h0004);
        #1;
        chk("bp_rdy1", bus.req1_ready, 1);
        tick();
        drive_req(1, 1'b0, 3'b000, 16'h0000, 16'h0000);
        drive_req(0, 1'b1, 3'b000, 16'h0005, 16'h0006);
        #1;
        chk("bp_exec_rdy0", bus.req0_ready, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_vld1", i), bus.rsp1_valid, 1);
            chk($sformatf("bp%0d_f1", i), bus.rsp1_f, 16'h000C);
            chk($sformatf("bp%0d_rdy0", i), bus.req0_ready, 0);
            chk($sformatf("bp%0d_vld0", i), bus.rsp0_valid, 0);
            tick();
        end
        bus.rsp1_ready = 1'b1;
        #1;
        chk("bp_last_vld1", bus.rsp1_valid, 1);
        chk("bp_last_rdy0", bus.req0_ready, 0);
        tick();
        chk("bp_idle_rdy0", bus.req0_ready, 1);
        chk("bp_idle_busy", bus.busy, 0);
        tick();
        drive_req(0, 1'b0, 3'b000, 16'h0000, 16'h0000);
        tick();
        chk("bp_r0_vld", bus.rsp0_valid, 1);
        chk("bp_r0_f", bus.rsp0_f, 16'h000B);
        tick();
        chk("bp_r0_idle", bus.busy, 0);

        // Reset during EXEC (last served is 0, so a tie would favour 1 without reset).
        drive_req(1, 1'b1, 3'b000, 16'h0007, 16'h0008);
        #1;
        tick();
        drive_req(1, 1'b0, 3'b000, 16'h0000, 16'h0000);
        chk("rx_exec_busy", bus.busy, 1);
        rst = 1'b1;
        tick();
        check_reset_outputs("rst_exec");
        drive_req(0, 1'b1, 3'b000, 16'h0001, 16'h0001);
        drive_req(1, 1'b1, 3'b000, 16'h0002, 16'h0002);
        #1;
        chk("rst_hold_rdy", {bus.req0_ready, bus.req1_ready}, 0);
        rst = 1'b0;
        #1;
        chk("rst_exec_tie0", bus.req0_ready, 1);
        chk("rst_exec_tie1", bus.req1_ready, 0);
        drive_req(0, 1'b0, 3'b000, 16'h0000, 16'h0000);
        drive_req(1, 1'b0, 3'b000, 16'h0000, 16'h0000);
        #1;

        // Reset during RESP holding a divide-by-zero result.
        do_op("pre_resp", 0, 3'b000, 16'h0002, 16'h0003, 16'h0005, 1'b0);
        bus.rsp0_ready = 1'b0;
        drive_req(0, 1'b1, 3'b011, 16'h0009, 16'h0000);
        #1;
        tick();
        drive_req(0, 1'b0, 3'b000, 16'h0000, 16'h0000);
        tick();
        chk("rr_vld", bus.rsp0_valid, 1);
        chk("rr_err", bus.rsp0_err, 1);
        rst = 1'b1;
        tick();
        check_reset_outputs("rst_resp");
        rst = 1'b0;
        drive_req(0, 1'b1, 3'b000, 16'h0001, 16'h0001);
        drive_req(1, 1'b1, 3'b000, 16'h0002, 16'h0002);
        #1;
        chk("rst_resp_tie0", bus.req0_ready, 1);
        chk("rst_resp_tie1", bus.req1_ready, 0);
        drive_req(0, 1'b0, 3'b000, 16'h0000, 16'h0000);
        drive_req(1, 1'b0, 3'b000, 16'h0000, 16'h0000);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
